// File: rtl/dht11_uart_reporter_pkg.sv
// Shared FSM encodings, message length and ASCII constants for the DHT11 UART reporter.
package dht11_uart_reporter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_SEND    = 2'd2
  } state_e;

  localparam int MSG_LEN = 15;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_T     = 8'h54;
  localparam logic [7:0] ASCII_H     = 8'h48;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_PCT   = 8'h25;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/dht11_uart_reporter_bin2bcd8.sv
// Sequential double-dabble: 8-bit binary to 3 BCD digits, one shift per cycle after a load cycle.
module bin2bcd8_seq #(
  parameter int DIGIT_CYCLES = 8
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic [7:0]  iBin,
  output logic        oBusy,
  output logic        oDone,
  output logic [11:0] oBcd
);

  localparam int CW = $clog2(DIGIT_CYCLES) + 1;

  logic [7:0]    bin_q, bin_d;
  logic [11:0]   bcd_q, bcd_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    adj = bcd_q;
    if (bcd_q[3:0]  >= 4'd5) adj[3:0]  = bcd_q[3:0]  + 4'd3;
    if (bcd_q[7:4]  >= 4'd5) adj[7:4]  = bcd_q[7:4]  + 4'd3;
    if (bcd_q[11:8] >= 4'd5) adj[11:8] = bcd_q[11:8] + 4'd3;
  end

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (iStart) begin
      bin_d  = iBin;
      bcd_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Hundreds never exceeds 2 for 8-bit input, so the dropped MSB is always 0.
      {bcd_d, bin_d} = {adj[10:0], bin_q, 1'b0};
      cnt_d          = cnt_q + 1'b1;
      if (cnt_q == CW'(DIGIT_CYCLES - 1)) busy_d = 1'b0;
    end
  end

  // Done flags the final shift cycle so the caller can advance on the same edge.
  assign oDone = busy_q && (cnt_q == CW'(DIGIT_CYCLES - 1));
  assign oBusy = busy_q;
  assign oBcd  = bcd_q;

endmodule

// File: rtl/dht11_uart_reporter.sv
// Snapshots DHT11 readings on trigger, converts to BCD and streams a 15-byte ASCII report.
module dht11_uart_reporter
  import dht11_uart_reporter_pkg::*;
#(
  parameter logic [7:0] TEMP_UNIT_CHAR = 8'h43,
  parameter int         DIGIT_CYCLES   = 8
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iTrigger,
  input  logic [7:0] iHumInt,
  input  logic [7:0] iTempInt,
  input  logic       iDataValid,
  output logic [7:0] oTxData,
  output logic       oTxValid,
  input  logic       iTxReady,
  output logic       oBusy,
  output logic       oDone
);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  hum_q, hum_d, temp_q, temp_d;
  logic        done_q, done_d;
  logic        start_q, start_d;
  logic        t_busy, h_busy, t_done, h_done;
  logic [11:0] t_bcd, h_bcd;
  logic [7:0]  tx_data;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hum_q   <= '0;
      temp_q  <= '0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hum_q   <= hum_d;
      temp_q  <= temp_d;
      done_q  <= done_d;
      start_q <= start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hum_d   = hum_q;
    temp_d  = temp_q;
    done_d  = 1'b0;
    start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iTrigger && iDataValid) begin
          hum_d   = iHumInt;
          temp_d  = iTempInt;
          start_d = 1'b1;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (t_done && h_done) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end else if (!start_q && !t_busy && !h_busy) begin
          // Converters idle without a pending load: abandon rather than hang.
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (iTxReady) begin
          if (idx_q == 4'(MSG_LEN - 1)) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Converters load from the snapshot on the first CONVERT cycle.
  bin2bcd8_seq #(.DIGIT_CYCLES(DIGIT_CYCLES)) u_temp_bcd (
    .iClk(iClk), .iRst(iRst), .iStart(start_q), .iBin(temp_q),
    .oBusy(t_busy), .oDone(t_done), .oBcd(t_bcd)
  );

  bin2bcd8_seq #(.DIGIT_CYCLES(DIGIT_CYCLES)) u_hum_bcd (
    .iClk(iClk), .iRst(iRst), .iStart(start_q), .iBin(hum_q),
    .oBusy(h_busy), .oDone(h_done), .oBcd(h_bcd)
  );

  always_comb begin
    tx_data = 8'h00;
    if (state_q == ST_SEND) begin
      case (idx_q)
        4'd0:    tx_data = ASCII_T;
        4'd1:    tx_data = ASCII_EQ;
        4'd2:    tx_data = digit_char(t_bcd[11:8]);
        4'd3:    tx_data = digit_char(t_bcd[7:4]);
        4'd4:    tx_data = digit_char(t_bcd[3:0]);
        4'd5:    tx_data = TEMP_UNIT_CHAR;
        4'd6:    tx_data = ASCII_SPACE;
        4'd7:    tx_data = ASCII_H;
        4'd8:    tx_data = ASCII_EQ;
        4'd9:    tx_data = digit_char(h_bcd[11:8]);
        4'd10:   tx_data = digit_char(h_bcd[7:4]);
        4'd11:   tx_data = digit_char(h_bcd[3:0]);
        4'd12:   tx_data = ASCII_PCT;
        4'd13:   tx_data = ASCII_CR;
        4'd14:   tx_data = ASCII_LF;
        default: tx_data = 8'h00;
      endcase
    end
  end

  assign oTxData  = tx_data;
  assign oTxValid = (state_q == ST_SEND);
  assign oBusy    = (state_q != ST_IDLE);
  assign oDone    = done_q;

endmodule

// File: doc/dht11_uart_reporter.md
DHT11_UART_REPORTER -- requirements
Module: dht11_uart_reporter

Interface
REQ-001 SHALL have parameter TEMP_UNIT_CHAR, default 8'h43 ('C'), which is the byte sent after the temperature digits.
REQ-002 SHALL have parameter DIGIT_CYCLES, default 8, which is the number of shift steps per binary-to-BCD conversion and is fixed at the 8-bit input width.
REQ-003 iClk  input  1  system clock.
REQ-004 iRst  input  1  asynchronous, active-high reset.
REQ-005 iTrigger  input  1  single-cycle report request.
REQ-006 iHumInt  input  8  humidity integer from the DHT11 controller.
REQ-007 iTempInt  input  8  temperature integer from the DHT11 controller.
REQ-008 iDataValid  input  1  sticky level; 1 once at least one checksum-valid sample exists.
REQ-009 oTxData  output  8  ASCII byte presented to the UART transmitter.
REQ-010 oTxValid  output  1  oTxData is valid.
REQ-011 iTxReady  input  1  UART transmitter accepts the byte.
REQ-012 oBusy  output  1  report in progress (CONVERT or SEND state).
REQ-013 oDone  output  1  single-cycle pulse after the last byte is accepted.

Function
REQ-014 SHALL implement a 3-state FSM with states IDLE, CONVERT and SEND.
REQ-015 IDLE: iTrigger=1 with iDataValid=1 -> snapshot iHumInt/iTempInt into internal registers, clear the conversion counter, go to CONVERT.
REQ-016 IDLE: iTrigger=1 with iDataValid=0 -> ignore the trigger, stay IDLE, no output change.
REQ-017 CONVERT: run a double-dabble conversion on both snapshots in parallel, one shift per cycle, for exactly DIGIT_CYCLES cycles, then go to SEND with byte index 0.
REQ-018 Each conversion SHALL give 3 BCD digits (hundreds, tens, ones) per value; range 0-255; no leading-zero suppression.
REQ-019 SEND: drive oTxValid=1 and oTxData = message[index], where the message is 15 bytes: 'T','=',Th,Tt,To,TEMP_UNIT_CHAR,' ','H','=',Hh,Ht,Ho,'%',8'h0D,8'h0A.
REQ-020 A digit byte SHALL equal 8'h30 + BCD digit.
REQ-021 Handshake: a byte is transferred in a cycle where oTxValid && iTxReady; on that edge the index increments.
REQ-022 While oTxValid=1 and iTxReady=0, oTxData and oTxValid SHALL hold stable.
REQ-023 Transfer of index 14 -> next state IDLE, oTxValid=0, and oDone=1 for exactly one cycle.
REQ-024 Latency: with the trigger sampled at edge 0, oTxValid SHALL first be 1 in the cycle after edge DIGIT_CYCLES+1 (cycle 9 by default).
REQ-025 With iTxReady held at 1, the full report SHALL take 15 consecutive cycles.
REQ-026 iTrigger in CONVERT or SEND SHALL be ignored; no queuing, and the snapshot is not modified.
REQ-027 Changes on iHumInt/iTempInt after the snapshot SHALL NOT affect the current report.
REQ-028 oBusy SHALL be 1 exactly when the state is CONVERT or SEND.
REQ-029 oTxValid SHALL be 0 in IDLE and CONVERT.
REQ-030 iTrigger coincident with the oDone cycle (state IDLE) SHALL be accepted normally.

Reset
REQ-031 iRst SHALL asynchronously force state IDLE, oTxData=8'h00, oTxValid=0, oBusy=0, oDone=0, byte index 0, conversion counter 0, snapshots 0 and BCD registers 0.
REQ-032 Reset asserted mid-SEND SHALL drop oTxValid immediately; after release no partial message resumes.

Structure
REQ-033 The shared package SHALL hold the FSM state encodings, MSG_LEN=15 and the ASCII constants (CR, LF, '0', 'T', 'H', '=', '%', space).
REQ-034 The sequential double-dabble converter SHALL be one sub-module, bin2bcd8_seq (start, busy/done, 8-bit in, 12-bit BCD out), instantiated twice.
REQ-035 The top level SHALL contain the FSM, the snapshot registers and the byte multiplexer.

Verification
REQ-036 Temp=25, Hum=60, valid=1, trigger, iTxReady=1 -> bytes 54 3D 30 32 35 43 20 48 3D 30 36 30 25 0D 0A, then one oDone pulse.
REQ-037 Temp=255, Hum=0 -> digit bytes 32 35 35 and 30 30 30; Temp=0, Hum=199 -> 30 30 30 and 31 39 39.
REQ-038 iTxReady toggling randomly -> the same 15-byte sequence with no drop or duplicate, and oTxData stable while stalled.
REQ-039 Trigger with iDataValid=0 -> oBusy and oTxValid stay 0 for 30 cycles; a second trigger during SEND produces no extra message.
REQ-040 Inputs changed from 25/60 to 30/70 at cycle 3 after trigger -> the report still shows 025/060.
REQ-041 Reset asserted at byte index 7 -> outputs return to reset values at once; a new trigger gives a complete fresh 15-byte message.
